// File: rtl/snn_pkg.sv
// Shared definitions for the spike input path.
//   MAX_SPIKE : maximum indices carried by one batch (matches the input interface)
//   IDX_W     : width of one spike index
//   CNT_W     : width of a spike count
//   fetch_state_e : state encoding of the spike fetch controller
package snn_pkg;

  localparam int MAX_SPIKE = 128;
  localparam int IDX_W     = 14;
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DONE     = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/spike_index_mux.sv
// MAX_SPIKE:1 read mux over the flat index bus held by the input interface.
//   index_flat : MAX_SPIKE entries of IDX_W bits, entry k at [k*IDX_W +: IDX_W]
//   sel        : entry to read
//   index_out  : selected entry
module spike_index_mux #(
  parameter int MAX_SPIKE = 128,
  parameter int IDX_W     = 14,
  parameter int SEL_W     = $clog2(MAX_SPIKE)
) (
  input  logic [IDX_W*MAX_SPIKE-1:0] index_flat,
  input  logic [SEL_W-1:0]           sel,
  output logic [IDX_W-1:0]           index_out
);

  always_comb begin
    index_out = index_flat[int'(sel)*IDX_W +: IDX_W];
  end

endmodule

// File: rtl/spike_fetch_ctrl.sv
// Sequencer between the input spike interface and the synapse/neuron core.
// Accepts one held batch, streams its indices one per valid/ready handshake,
// then pulses fetch_done so the interface can re-arm.
//   clk, rst_n     : clock (rising edge), synchronous active-low reset
//   batch_valid    : interface holds a new batch
//   batch_ack      : one-cycle pulse, batch accepted
//   num_spike_in   : spike count of the held batch (clamped to MAX_SPIKE)
//   index_in_flat  : held indices, entry k at [k*IDX_W +: IDX_W]
//   flush          : abort the current batch
//   spike_valid/spike_index/spike_ready/spike_last : stream to the core
//   fetch_done     : one-cycle pulse, batch finished (or flushed)
//   busy           : controller not idle
//   dispatched_cnt : spikes accepted in the current/last batch
module spike_fetch_ctrl
  import snn_pkg::*;
#(
  parameter int MAX_SPIKE = snn_pkg::MAX_SPIKE,
  parameter int IDX_W     = snn_pkg::IDX_W,
  parameter int CNT_W     = snn_pkg::CNT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       batch_valid,
  output logic                       batch_ack,
  input  logic [CNT_W-1:0]           num_spike_in,
  input  logic [IDX_W*MAX_SPIKE-1:0] index_in_flat,
  input  logic                       flush,
  output logic                       spike_valid,
  output logic [IDX_W-1:0]           spike_index,
  input  logic                       spike_ready,
  output logic                       spike_last,
  output logic                       fetch_done,
  output logic                       busy,
  output logic [CNT_W-1:0]           dispatched_cnt
);

  localparam int PTR_W = $clog2(MAX_SPIKE) + 1;
  localparam int SEL_W = $clog2(MAX_SPIKE);

  fetch_state_e     state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] cnt_lat_q, cnt_lat_d;
  logic [CNT_W-1:0] dispatched_cnt_q, dispatched_cnt_d;

  logic [PTR_W-1:0] cnt_clamped;
  logic [IDX_W-1:0] mux_index;
  logic             at_last;

  // ptr only reaches MAX_SPIKE after the final transfer, when the state has
  // already left DISPATCH, so the low bits are enough to address the bus.
  spike_index_mux #(
    .MAX_SPIKE (MAX_SPIKE),
    .IDX_W     (IDX_W),
    .SEL_W     (SEL_W)
  ) u_index_mux (
    .index_flat (index_in_flat),
    .sel        (ptr_q[SEL_W-1:0]),
    .index_out  (mux_index)
  );

  always_comb begin
    if (int'(num_spike_in) > MAX_SPIKE) begin
      cnt_clamped = PTR_W'(MAX_SPIKE);
    end else begin
      cnt_clamped = PTR_W'(num_spike_in);
    end
  end

  assign at_last = (ptr_q + PTR_W'(1)) == cnt_lat_q;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    cnt_lat_d        = cnt_lat_q;
    dispatched_cnt_d = dispatched_cnt_q;
    batch_ack        = 1'b0;
    spike_valid      = 1'b0;
    spike_index      = '0;
    spike_last       = 1'b0;
    fetch_done       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (batch_valid && !flush) begin
          batch_ack        = 1'b1;
          cnt_lat_d        = cnt_clamped;
          ptr_d            = '0;
          dispatched_cnt_d = '0;
          state_d          = (cnt_clamped == '0) ? DONE : DISPATCH;
        end
      end
      DISPATCH: begin
        spike_valid = 1'b1;
        spike_index = mux_index;
        spike_last  = at_last;
        // Flush wins over a same-cycle handshake: that spike is not counted.
        if (flush) begin
          state_d = DONE;
        end else if (spike_ready) begin
          ptr_d            = ptr_q + PTR_W'(1);
          dispatched_cnt_d = dispatched_cnt_q + CNT_W'(1);
          if (at_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        fetch_done = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy           = (state_q != IDLE);
  assign dispatched_cnt = dispatched_cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      ptr_q            <= '0;
      cnt_lat_q        <= '0;
      dispatched_cnt_q <= '0;
    end else begin
      state_q          <= state_d;
      ptr_q            <= ptr_d;
      cnt_lat_q        <= cnt_lat_d;
      dispatched_cnt_q <= dispatched_cnt_d;
    end
  end

endmodule

// File: tb/tb_spike_fetch_ctrl.sv
// Directed testbench for spike_fetch_ctrl. Inputs are driven 1 ns after the
// rising edge and outputs sampled 1 ns later, well away from the next edge.
module tb_spike_fetch_ctrl;
  import snn_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       batch_valid;
  logic                       batch_ack;
  logic [CNT_W-1:0]           num_spike_in;
  logic [IDX_W*MAX_SPIKE-1:0] index_in_flat;
  logic                       flush;
  logic                       spike_valid;
  logic [IDX_W-1:0]           spike_index;
  logic                       spike_ready;
  logic                       spike_last;
  logic                       fetch_done;
  logic                       busy;
  logic [CNT_W-1:0]           dispatched_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spike_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .batch_valid    (batch_valid),
    .batch_ack      (batch_ack),
    .num_spike_in   (num_spike_in),
    .index_in_flat  (index_in_flat),
    .flush          (flush),
    .spike_valid    (spike_valid),
    .spike_index    (spike_index),
    .spike_ready    (spike_ready),
    .spike_last     (spike_last),
    .fetch_done     (fetch_done),
    .busy           (busy),
    .dispatched_cnt (dispatched_cnt)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance one clock, land 1 ns after the edge for the next drive.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after a drive.
  task automatic settle();
    #1;
  endtask

  task automatic set_idx(input int k, input logic [IDX_W-1:0] v);
    index_in_flat[k*IDX_W +: IDX_W] = v;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ack"},   32'(batch_ack),      32'd0);
    check({tag, "_valid"}, 32'(spike_valid),    32'd0);
    check({tag, "_index"}, 32'(spike_index),    32'd0);
    check({tag, "_last"},  32'(spike_last),     32'd0);
    check({tag, "_done"},  32'(fetch_done),     32'd0);
    check({tag, "_busy"},  32'(busy),           32'd0);
    check({tag, "_cnt"},   32'(dispatched_cnt), 32'd0);
  endtask

  logic [IDX_W-1:0] tog_exp [8];
  int n_xfer, xfer_cyc, done_cyc, bad_idx, last_at, n_last;

  initial begin
    rst_n         = 1'b0;
    batch_valid   = 1'b0;
    num_spike_in  = '0;
    index_in_flat = '0;
    flush         = 1'b0;
    spike_ready   = 1'b0;
    #1;
    step();
    step();

    // ---- reset state
    settle();
    check_idle_outputs("rst");
    rst_n = 1'b1;
    step();

    // ---- batch of 3, ready tied high
    set_idx(0, 14'd100);
    set_idx(1, 14'd7);
    set_idx(2, 14'd16383);
    num_spike_in = 8'd3;
    batch_valid  = 1'b1;
    spike_ready  = 1'b1;
    settle();
    check("b3_ack", 32'(batch_ack), 32'd1);
    step();
    batch_valid = 1'b0;
    settle();
    check("b3_v0", 32'(spike_valid), 32'd1);
    check("b3_i0", 32'(spike_index), 32'd100);
    check("b3_l0", 32'(spike_last),  32'd0);
    check("b3_ack_pulse", 32'(batch_ack), 32'd0);
    step();
    settle();
    check("b3_i1", 32'(spike_index), 32'd7);
    check("b3_l1", 32'(spike_last),  32'd0);
    step();
    settle();
    check("b3_i2", 32'(spike_index), 32'd16383);
    check("b3_l2", 32'(spike_last),  32'd1);
    step();
    settle();
    check("b3_done",  32'(fetch_done),     32'd1);
    check("b3_valid", 32'(spike_valid),    32'd0);
    check("b3_cnt",   32'(dispatched_cnt), 32'd3);
    step();
    settle();
    check("b3_done_pulse", 32'(fetch_done),     32'd0);
    check("b3_busy",       32'(busy),           32'd0);
    check("b3_cnt_hold",   32'(dispatched_cnt), 32'd3);

    // ---- batch of 4, ready high every third cycle
    tog_exp = '{14'd11, 14'd22, 14'd33, 14'd44, 14'd0, 14'd0, 14'd0, 14'd0};
    for (int k = 0; k < 4; k++) set_idx(k, tog_exp[k]);
    num_spike_in = 8'd4;
    batch_valid  = 1'b1;
    spike_ready  = 1'b0;
    settle();
    check("tog_ack", 32'(batch_ack), 32'd1);
    step();
    batch_valid = 1'b0;
    n_xfer   = 0;
    xfer_cyc = -1;
    done_cyc = -1;
    for (int c = 0; c < 40 && done_cyc < 0; c++) begin
      spike_ready = (c % 3 == 0);
      settle();
      if (fetch_done) begin
        done_cyc = c;
      end else if (spike_valid) begin
        check("tog_idx",  32'(spike_index), 32'(tog_exp[n_xfer % 8]));
        check("tog_last", 32'(spike_last),  32'(n_xfer == 3));
        if (spike_ready) begin
          n_xfer++;
          xfer_cyc = c;
        end
      end
      step();
    end
    check("tog_xfers",     32'(n_xfer),   32'd4);
    check("tog_done_cyc",  32'(done_cyc), 32'd10);
    check("tog_last_xfer", 32'(xfer_cyc), 32'd9);
    check("tog_cnt",       32'(dispatched_cnt), 32'd4);

    // ---- zero-spike batch; batch_valid left high through DONE
    num_spike_in = 8'd0;
    batch_valid  = 1'b1;
    spike_ready  = 1'b1;
    settle();
    check("z_ack", 32'(batch_ack), 32'd1);
    step();
    settle();
    check("z_done",    32'(fetch_done),     32'd1);
    check("z_valid",   32'(spike_valid),    32'd0);
    check("z_cnt",     32'(dispatched_cnt), 32'd0);
    check("z_ack_ign", 32'(batch_ack),      32'd0);
    batch_valid = 1'b0;
    step();
    settle();
    check("z_busy",  32'(busy),        32'd0);
    check("z_valid2", 32'(spike_valid), 32'd0);

    // ---- count of 200 clamps to MAX_SPIKE
    for (int k = 0; k < MAX_SPIKE; k++) set_idx(k, IDX_W'(1000 + 3 * k));
    num_spike_in = 8'd200;
    batch_valid  = 1'b1;
    spike_ready  = 1'b1;
    settle();
    check("cl_ack", 32'(batch_ack), 32'd1);
    step();
    batch_valid = 1'b0;
    n_xfer   = 0;
    bad_idx  = 0;
    last_at  = -1;
    n_last   = 0;
    done_cyc = -1;
    for (int c = 0; c < 300 && done_cyc < 0; c++) begin
      settle();
      if (fetch_done) begin
        done_cyc = c;
      end else if (spike_valid) begin
        if (spike_index !== IDX_W'(1000 + 3 * n_xfer)) bad_idx++;
        if (spike_last) begin
          last_at = n_xfer;
          n_last++;
        end
        n_xfer++;
      end
      step();
    end
    check("cl_xfers",   32'(n_xfer),  32'd128);
    check("cl_bad_idx", 32'(bad_idx), 32'd0);
    check("cl_last_at", 32'(last_at), 32'd127);
    check("cl_n_last",  32'(n_last),  32'd1);
    check("cl_done",    32'(done_cyc), 32'd128);
    check("cl_cnt",     32'(dispatched_cnt), 32'd128);

    // ---- flush after 4 transfers of a 10-spike batch
    num_spike_in = 8'd10;
    batch_valid  = 1'b1;
    spike_ready  = 1'b1;
    settle();
    check("fl_ack", 32'(batch_ack), 32'd1);
    step();
    batch_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    flush = 1'b1;
    settle();
    check("fl_valid", 32'(spike_valid), 32'd1);
    check("fl_index", 32'(spike_index), 32'd1012);
    step();
    flush = 1'b0;
    settle();
    check("fl_done", 32'(fetch_done),     32'd1);
    check("fl_cnt",  32'(dispatched_cnt), 32'd4);
    step();
    settle();
    check("fl_busy", 32'(busy),           32'd0);
    check("fl_hold", 32'(dispatched_cnt), 32'd4);

    // ---- flush in IDLE blocks acceptance
    num_spike_in = 8'd2;
    batch_valid  = 1'b1;
    flush        = 1'b1;
    settle();
    check("fi_ack", 32'(batch_ack), 32'd0);
    step();
    settle();
    check("fi_busy", 32'(busy), 32'd0);
    batch_valid = 1'b0;
    flush       = 1'b0;
    step();

    // ---- reset mid-DISPATCH, then a fresh batch is accepted
    num_spike_in = 8'd5;
    batch_valid  = 1'b1;
    spike_ready  = 1'b1;
    settle();
    check("rd_ack", 32'(batch_ack), 32'd1);
    step();
    batch_valid = 1'b0;
    step();
    step();
    settle();
    check("rd_pre_index", 32'(spike_index),    32'd1006);
    check("rd_pre_cnt",   32'(dispatched_cnt), 32'd2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    settle();
    check_idle_outputs("rd");
    step();
    settle();
    check("rd_no_done", 32'(fetch_done), 32'd0);
    num_spike_in = 8'd1;
    batch_valid  = 1'b1;
    settle();
    check("rd_new_ack", 32'(batch_ack), 32'd1);
    step();
    batch_valid = 1'b0;
    settle();
    check("rd_new_idx",  32'(spike_index), 32'd1000);
    check("rd_new_last", 32'(spike_last),  32'd1);
    step();
    settle();
    check("rd_new_done", 32'(fetch_done),     32'd1);
    check("rd_new_cnt",  32'(dispatched_cnt), 32'd1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
